ttt_tick_sequencer: RTL and testbench

Host-side sequencer that sits directly upstream of the tick-tock-tokens processor top level and drives its 4-bit instruction / 8-bit data interface. Token-add requests from the surrounding logic are buffered in a small FIFO. On each timestep tick the block then:

- drains the FIFO into add-good/add-bad instructions,
- issues tally (4'b1000) and countdown (4'b1001),
- captures the processor's registered start/stop flags,
- reports one event per timestep.

---
 rtl/ttt_pkg.sv | 28 ++
 rtl/ttt_token_fifo.sv | 60 ++++++
 rtl/ttt_tick_sequencer.sv | 137 +++++++++++++
 tb/tb_ttt_tick_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tick-tock-tokens host sequencer.
//   OP_*        : processor opcodes driven on the 4-bit instruction bus
//   seq_state_t : sequencer state encoding
//   tok_req_t   : one token-add request, laid out as the processor data word
package ttt_pkg;

  localparam logic [3:0] OP_ADD_GOOD  = 4'b0000;
  localparam logic [3:0] OP_ADD_BAD   = 4'b0001;
  localparam logic [3:0] OP_GET_GOOD  = 4'b0011;  // read-only, used as NOP
  localparam logic [3:0] OP_TALLY     = 4'b1000;
  localparam logic [3:0] OP_COUNTDOWN = 4'b1001;

  localparam int TOK_COUNT_BITS = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TALLY,
    ST_COUNT,
    ST_CAPTURE
  } seq_state_t;

  typedef struct packed {
    logic                      bad;
    logic [TOK_COUNT_BITS-1:0] count;
  } tok_req_t;

endpackage

// File: rtl/ttt_token_fifo.sv
// Synchronous FIFO buffering token-add requests between ticks.
//   clk, rst_n             : clock, synchronous active-low reset (flushes)
//   push_valid/push_ready  : write handshake, push_data written on valid&ready
//   pop                    : remove head (ignored when empty)
//   pop_data               : current head entry
//   empty, full, count     : occupancy status
module ttt_token_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ttt_tick_sequencer.sv
// Host sequencer in front of the tick-tock-tokens processor. Buffers
// token-add requests and, on each tick, drains them as add instructions,
// then issues tally and countdown and reports the start/stop flags.
//   clk, rst_n                     : clock, synchronous active-low reset
//   tick_i                         : timestep strobe
//   tok_valid_i/tok_ready_o        : token request handshake
//   tok_bad_i, tok_count_i         : token request payload
//   proc_instr_o, proc_data_o      : processor instruction / data bus
//   proc_result_i                  : processor registered result
//   event_valid_o, start_o, stop_o : per-timestep event and flags
//   tick_count_o                   : completed timesteps (mod 256)
//   busy_o                         : sequence in progress
//   overrun_o                      : pulse when a tick arrived while busy
module ttt_tick_sequencer
  import ttt_pkg::*;
#(
  parameter int COUNT_BITS       = 7,
  parameter int DATA_BITS        = 8,
  parameter int INSTRUCTION_BITS = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick_i,
  input  logic                        tok_valid_i,
  output logic                        tok_ready_o,
  input  logic                        tok_bad_i,
  input  logic [COUNT_BITS-1:0]       tok_count_i,
  output logic [INSTRUCTION_BITS-1:0] proc_instr_o,
  output logic [DATA_BITS-1:0]        proc_data_o,
  input  logic [DATA_BITS-1:0]        proc_result_i,
  output logic                        event_valid_o,
  output logic                        start_o,
  output logic                        stop_o,
  output logic [7:0]                  tick_count_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_t           state;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_ready;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 in_drain;
  logic                 st;
  logic                 sp;
  logic                 unused_bits;

  function automatic logic [INSTRUCTION_BITS-1:0] op(input logic [3:0] code);
    return INSTRUCTION_BITS'(code);
  endfunction

  assign in_drain    = (state == ST_DRAIN);
  assign tok_ready_o = fifo_ready && !in_drain;
  assign busy_o      = (state != ST_IDLE);

  // Only the two flag bits of the result are meaningful to this block.
  assign unused_bits = ^{proc_result_i[DATA_BITS-1:2], fifo_full};

  ttt_token_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (tok_valid_i && !in_drain),
    .push_ready (fifo_ready),
    .push_data  (DATA_BITS'({tok_bad_i, tok_count_i})),
    .pop        (in_drain),
    .pop_data   (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_comb begin
    proc_instr_o = op(OP_GET_GOOD);
    proc_data_o  = '0;
    case (state)
      ST_DRAIN: begin
        proc_instr_o = head[DATA_BITS-1] ? op(OP_ADD_BAD) : op(OP_ADD_GOOD);
        proc_data_o  = head;
      end
      ST_TALLY: proc_instr_o = op(OP_TALLY);
      ST_COUNT: proc_instr_o = op(OP_COUNTDOWN);
      default:  proc_instr_o = op(OP_GET_GOOD);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      event_valid_o <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      overrun_o     <= 1'b0;
      tick_count_o  <= 8'd0;
    end else begin
      event_valid_o <= 1'b0;
      overrun_o     <= tick_i && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (tick_i) state <= fifo_empty ? ST_TALLY : ST_DRAIN;
        end
        ST_DRAIN: begin
          // The entry popped this cycle is the last one.
          if (fifo_count == CNT_W'(1)) state <= ST_TALLY;
        end
        ST_TALLY: state <= ST_COUNT;
        ST_COUNT: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          state         <= ST_IDLE;
          event_valid_o <= 1'b1;
          start_o       <= st;
          stop_o        <= sp | proc_result_i[0];
          tick_count_o  <= tick_count_o + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flag capture: COUNT sees the tally response, CAPTURE the countdown response.
  always_ff @(posedge clk) begin
    if (state == ST_COUNT) begin
      st <= proc_result_i[1];
      sp <= proc_result_i[0];
    end else if (state == ST_CAPTURE) begin
      sp <= sp | proc_result_i[0];
    end
  end

endmodule

// File: tb/tb_ttt_tick_sequencer.sv
module tb_ttt_tick_sequencer;
  import ttt_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_i = 1'b0;
  logic       tok_valid_i = 1'b0;
  logic       tok_ready_o;
  logic       tok_bad_i = 1'b0;
  logic [6:0] tok_count_i = '0;
  logic [3:0] proc_instr_o;
  logic [7:0] proc_data_o;
  logic [7:0] proc_result_i;
  logic       event_valid_o, start_o, stop_o, busy_o, overrun_o;
  logic [7:0] tick_count_o;

  always #5 clk = ~clk;

  ttt_tick_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .tok_valid_i   (tok_valid_i),
    .tok_ready_o   (tok_ready_o),
    .tok_bad_i     (tok_bad_i),
    .tok_count_i   (tok_count_i),
    .proc_instr_o  (proc_instr_o),
    .proc_data_o   (proc_data_o),
    .proc_result_i (proc_result_i),
    .event_valid_o (event_valid_o),
    .start_o       (start_o),
    .stop_o        (stop_o),
    .tick_count_o  (tick_count_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  typedef struct {int cyc; logic [3:0] op; logic [7:0] data; bit chk;} instr_t;
  typedef struct {int cyc; bit st; bit sp; logic [7:0] tc;} ev_t;
  typedef struct packed {bit st; bit spt; bit spc;} stub_t;

  instr_t   exp_instr[$];
  ev_t      exp_ev[$];
  int       exp_ov[$];
  stub_t    stub_q[$];
  tok_req_t model_q[$];

  int         cyc = 0;
  bit         active = 0;
  int         seq_t = 0, seq_k = 0;
  logic [7:0] model_tc = 0;
  bit         exp_ready = 0, exp_busy = 0, en = 0;
  int         rst_at = -1;
  bit         nxt_st = 0, nxt_spt = 0, nxt_spc = 0;
  int         tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Processor stub: one-cycle response; flags for each timestep are drawn at tick time.
  stub_t cur = '0;
  always @(posedge clk) begin
    if (proc_instr_o == OP_TALLY) begin
      cur = (stub_q.size() > 0) ? stub_q.pop_front() : stub_t'(0);
      proc_result_i <= {6'($urandom), cur.st, cur.spt};
    end else if (proc_instr_o == OP_COUNTDOWN) begin
      proc_result_i <= {7'($urandom), cur.spc};
    end else begin
      proc_result_i <= 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic bit m_busy(input int c);
    return active && c >= seq_t + 1 && c <= seq_t + seq_k + 3;
  endfunction

  function automatic bit m_drain(input int c);
    return active && c >= seq_t + 1 && c <= seq_t + seq_k;
  endfunction

  // Timestep accepted at cycle c: everything queued is issued, then tally/countdown.
  task automatic start_seq(input int c);
    int k;
    k = model_q.size();
    seq_t = c;
    seq_k = k;
    active = 1;
    for (int i = 0; i < k; i++)
      exp_instr.push_back('{c + 1 + i, model_q[i].bad ? OP_ADD_BAD : OP_ADD_GOOD,
                            {model_q[i].bad, model_q[i].count}, 1'b1});
    exp_instr.push_back('{c + k + 1, OP_TALLY, 8'h00, 1'b0});
    exp_instr.push_back('{c + k + 2, OP_COUNTDOWN, 8'h00, 1'b0});
    stub_q.push_back('{nxt_st, nxt_spt, nxt_spc});
    model_tc = model_tc + 8'd1;
    exp_ev.push_back('{c + k + 4, nxt_st, nxt_spt | nxt_spc, model_tc});
    model_q.delete();
  endtask

  task automatic apply_reset(input int c);
    while (exp_instr.size() > 0 && exp_instr[$].cyc > c) void'(exp_instr.pop_back());
    while (exp_ev.size() > 0 && exp_ev[$].cyc > c) void'(exp_ev.pop_back());
    while (exp_ov.size() > 0 && exp_ov[$] > c) void'(exp_ov.pop_back());
    stub_q.delete();
    model_q.delete();
    active = 0;
    model_tc = 0;
    rst_at = c + 1;
  endtask

  // One clock cycle of stimulus; acc reports whether the request was taken.
  task automatic step(input bit tk, input bit vld, input tok_req_t req, input bit rst,
                      output bit acc);
    bit v;
    @(posedge clk);
    #1;
    exp_busy  = m_busy(cyc);
    exp_ready = !m_drain(cyc) && model_q.size() < DEPTH;
    v = vld && !rst && !(tk && !exp_busy);
    rst_n       = !rst;
    tick_i      = tk && !rst;
    tok_valid_i = v;
    tok_bad_i   = req.bad;
    tok_count_i = req.count;
    acc = v && exp_ready;
    if (rst) begin
      apply_reset(cyc);
    end else begin
      if (acc) model_q.push_back(req);
      if (tk) begin
        if (exp_busy) exp_ov.push_back(cyc + 1);
        else start_seq(cyc);
      end
    end
  endtask

  // Monitor / scoreboard.
  bit         last_st = 0, last_sp = 0, mon_e;
  logic [7:0] last_tc = 0;
  instr_t     mon_ei;
  ev_t        mon_ev;
  always @(negedge clk) begin
    if (en) begin
      if (cyc == rst_at) begin
        last_st = 0;
        last_sp = 0;
        last_tc = 0;
      end
      if (exp_instr.size() > 0 && exp_instr[0].cyc == cyc) begin
        mon_ei = exp_instr.pop_front();
        check("instr", proc_instr_o, mon_ei.op);
        if (mon_ei.chk) check("add_data", proc_data_o, mon_ei.data);
      end else begin
        check("instr_nop", proc_instr_o, OP_GET_GOOD);
        check("data_nop", proc_data_o, 8'h00);
      end
      mon_e = exp_ov.size() > 0 && exp_ov[0] == cyc;
      if (mon_e) void'(exp_ov.pop_front());
      check("overrun", overrun_o, mon_e);
      mon_e = exp_ev.size() > 0 && exp_ev[0].cyc == cyc;
      if (mon_e) begin
        mon_ev  = exp_ev.pop_front();
        last_st = mon_ev.st;
        last_sp = mon_ev.sp;
        last_tc = mon_ev.tc;
      end
      check("event_valid", event_valid_o, mon_e);
      check("start", start_o, last_st);
      check("stop", stop_o, last_sp);
      check("tick_count", tick_count_o, last_tc);
      check("tok_ready", tok_ready_o, exp_ready);
      check("busy", busy_o, exp_busy);
    end
  end

  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 0, '0, 0, a);
  endtask

  task automatic tick1();
    bit a;
    step(1, 0, '0, 0, a);
  endtask

  task automatic push1(input bit bad, input logic [6:0] cnt);
    bit a;
    step(0, 1, '{bad, cnt}, 0, a);
  endtask

  initial begin
    bit       acc, pend;
    tok_req_t r;
    int       guard;

    step(0, 0, '0, 1, acc);
    step(0, 0, '0, 1, acc);
    en = 1;

    // Idle tick, empty FIFO: start=1, stop=0.
    idle(2);
    {nxt_st, nxt_spt, nxt_spc} = 3'b100;
    tick1();
    idle(6);

    // Three queued adds then tick.
    push1(0, 7'd5);
    push1(1, 7'd3);
    push1(0, 7'd127);
    {nxt_st, nxt_spt, nxt_spc} = 3'($urandom);
    tick1();
    idle(9);

    // Fill FIFO, hold a fifth request across the drain.
    for (int i = 0; i < DEPTH; i++) push1(i[0], 7'(10 + i));
    r = '{1'b1, 7'd99};
    repeat (3) step(0, 1, r, 0, acc);
    step(1, 1, r, 0, acc);
    guard = 0;
    acc = 0;
    while (!acc && guard < 20) begin
      step(0, 1, r, 0, acc);
      guard++;
    end
    check("held_request_accepted", acc, 1'b1);
    idle(6);
    tick1();
    idle(8);

    // Tick during COUNT is dropped with an overrun pulse.
    tick1();
    idle(1);
    tick1();
    idle(5);

    // Stop only from countdown, then 256 back-to-back timesteps from zero.
    step(0, 0, '0, 1, acc);
    idle(1);
    for (int i = 0; i < 256; i++) begin
      if (i == 0) {nxt_st, nxt_spt, nxt_spc} = 3'b001;
      else {nxt_st, nxt_spt, nxt_spc} = 3'($urandom);
      tick1();
      idle(3);
    end
    idle(2);

    // Reset mid-drain with two entries left.
    for (int i = 0; i < DEPTH; i++) push1(1'b0, 7'(20 + i));
    tick1();
    idle(1);
    step(0, 0, '0, 1, acc);
    idle(2);
    tick1();
    idle(6);

    // Randomized traffic.
    pend = 0;
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        r = tok_req_t'($urandom);
        pend = 1;
      end
      {nxt_st, nxt_spt, nxt_spc} = 3'($urandom);
      step($urandom_range(0, 5) == 0, pend, r, $urandom_range(0, 399) == 0, acc);
      if (acc) pend = 0;
    end
    idle(12);

    check("pending_events", exp_ev.size(), 0);
    check("pending_instrs", exp_instr.size(), 0);
    check("pending_overruns", exp_ov.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
